// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART command processor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO   = 8'hEC;
    localparam logic [7:0] OP_ADD32  = 8'hAD;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_RESULT
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Payload byte count from the total packet length; short lengths mean no payload.
    function automatic logic [15:0] payload_len(input logic [15:0] total);
        return (total > 16'(HDR_BYTES)) ? (total - 16'(HDR_BYTES)) : 16'd0;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop sync, start-edge detect, mid-bit sampling, framing check.
// Latency: vld_o strobes one clock after the stop-bit midpoint sample.
// Backpressure: none; bytes must be consumed on the strobe, framing errors are dropped.
// Ports: clk_i/reset_i (sync, active-high), prescale (clocks per 1/8 bit),
//        rxd_i (async serial in, idle high), data_o/vld_o (received byte + 1-cycle strobe).
module uart_rx_byte (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] prescale,
    input  logic        rxd_i,
    output logic [7:0]  data_o,
    output logic        vld_o
);
    import uart_alu_pkg::*;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    rx_state_t   state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d;

    logic [18:0] bit_time;
    logic [18:0] half_bit;

    assign bit_time = {prescale, 3'b000};
    assign half_bit = {1'b0, prescale, 2'b00};

    always_comb begin
        sync1_d   = rxd_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                // Falling edge only, so a line held low after a bad stop bit is not a new start.
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = half_bit - 19'd1;
                end
            end
            RX_START: begin
                if (cnt_q != 19'd0) begin
                    cnt_d = cnt_q - 19'd1;
                end else if (!sync2_q) begin
                    state_d   = RX_DATA;
                    cnt_d     = bit_time - 19'd1;
                    bit_idx_d = 3'd0;
                end else begin
                    // Glitch: line back high at start-bit midpoint.
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != 19'd0) begin
                    cnt_d = cnt_q - 19'd1;
                end else begin
                    data_d    = {sync2_q, data_q[7:1]};
                    cnt_d     = bit_time - 19'd1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q != 19'd0) begin
                    cnt_d = cnt_q - 19'd1;
                end else begin
                    vld_d   = sync2_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an AXI-Stream byte input.
// Latency: start bit drives one clock after the tvalid/tready handshake.
// Backpressure: tready high when idle and in the last clock of the stop bit (no inter-frame gap).
// Ports: clk_i/reset_i (sync, active-high), s_axis_tdata/tvalid/tready (byte in),
//        txd_o (serial out, idle high), prescale (clocks per 1/8 bit).
module uart_tx (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        txd_o,
    input  logic [15:0] prescale
);
    logic        busy_q, busy_d;
    logic        tx_q, tx_d;
    logic [8:0]  shift_q, shift_d;
    logic [3:0]  bits_left_q, bits_left_d;
    logic [18:0] cnt_q, cnt_d;

    logic [18:0] bit_time;
    logic        frame_end;

    assign bit_time  = {prescale, 3'b000};
    assign frame_end = busy_q && (cnt_q == 19'd0) && (bits_left_q == 4'd0);
    assign s_axis_tready = !busy_q || frame_end;

    always_comb begin
        busy_d      = busy_q;
        tx_d        = tx_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        cnt_d       = cnt_q;
        if (s_axis_tvalid && s_axis_tready) begin
            busy_d      = 1'b1;
            tx_d        = 1'b0;
            shift_d     = {1'b1, s_axis_tdata};
            bits_left_d = 4'd9;
            cnt_d       = bit_time - 19'd1;
        end else if (busy_q) begin
            if (cnt_q != 19'd0) begin
                cnt_d = cnt_q - 19'd1;
            end else if (bits_left_q == 4'd0) begin
                busy_d = 1'b0;
            end else begin
                tx_d        = shift_q[0];
                shift_d     = {1'b1, shift_q[8:1]};
                bits_left_d = bits_left_q - 4'd1;
                cnt_d       = bit_time - 19'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
            shift_q     <= '1;
            bits_left_q <= '0;
            cnt_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            tx_q        <= tx_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            cnt_q       <= cnt_d;
        end
    end

    assign txd_o = tx_q;

endmodule

// File: rtl/uart_alu_top.sv
// UART command processor: parses length-prefixed packets, echoes or adds 32-bit operands.
// Latency: echo start bit 2 clocks after RX strobe; add32 result start bit 3 clocks after last byte.
// Backpressure: 4-byte TX FIFO drops pushes when full; add32 result waits for an empty FIFO
// while incoming RX bytes are dropped.
// Ports: clk_i (system clock), reset_i (sync, active-high), RX_i (serial in), TX_o (serial out).
module uart_alu_top #(
    parameter int CLK_FREQ_HZ = 31_500_000,
    parameter int BAUD_RATE   = 9600,
    parameter int PRESCALE    = CLK_FREQ_HZ / (BAUD_RATE * 8)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic RX_i,
    output logic TX_o
);
    import uart_alu_pkg::*;

    localparam logic [15:0] PRESCALE_W = 16'(PRESCALE);

    logic [7:0] rx_dat;
    logic       rx_vld;
    logic [7:0] tx_dat;
    logic       tx_vld;
    logic       tx_rdy;

    parse_state_t state_q, state_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   len_lo_q, len_lo_d;
    logic [15:0]  pay_cnt_q, pay_cnt_d;
    logic [31:0]  acc_q, acc_d;
    logic [23:0]  word_q, word_d;
    logic [1:0]   byte_idx_q, byte_idx_d;

    logic [7:0]   fifo_mem_q [4];
    logic [7:0]   fifo_mem_d [4];
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]   fifo_cnt_q, fifo_cnt_d;

    logic         fifo_empty;
    logic         fifo_full;
    logic         pop;
    logic         push;
    logic         push_ok;
    logic         result_wr;
    logic [15:0]  pay_len;

    uart_rx_byte u_rx (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .prescale (PRESCALE_W),
        .rxd_i    (RX_i),
        .data_o   (rx_dat),
        .vld_o    (rx_vld)
    );

    uart_tx u_tx (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .s_axis_tdata  (tx_dat),
        .s_axis_tvalid (tx_vld),
        .s_axis_tready (tx_rdy),
        .txd_o         (TX_o),
        .prescale      (PRESCALE_W)
    );

    assign fifo_empty = (fifo_cnt_q == 3'd0);
    assign fifo_full  = (fifo_cnt_q == 3'd4);
    assign tx_vld     = !fifo_empty;
    assign tx_dat     = fifo_mem_q[rd_ptr_q];
    assign pop        = tx_vld && tx_rdy;
    assign pay_len    = payload_len({rx_dat, len_lo_q});

    // Packet parser and accumulator.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        pay_cnt_d  = pay_cnt_q;
        acc_d      = acc_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        push       = 1'b0;
        result_wr  = 1'b0;
        case (state_q)
            ST_OPCODE: begin
                if (rx_vld) begin
                    opcode_d   = rx_dat;
                    acc_d      = '0;
                    byte_idx_d = '0;
                    state_d    = ST_RSVD;
                end
            end
            ST_RSVD: begin
                if (rx_vld) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (rx_vld) begin
                    len_lo_d = rx_dat;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_vld) begin
                    pay_cnt_d = pay_len;
                    if (pay_len != 16'd0) begin
                        state_d = ST_PAYLOAD;
                    end else if (opcode_q == OP_ADD32) begin
                        state_d = ST_RESULT;
                    end else begin
                        state_d = ST_OPCODE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_vld) begin
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    if (opcode_q == OP_ECHO) begin
                        push = 1'b1;
                    end
                    if (opcode_q == OP_ADD32) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        // Bytes 0..2 park in word_q; byte 3 completes the operand.
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = rx_dat;
                            2'd1:    word_d[15:8]  = rx_dat;
                            2'd2:    word_d[23:16] = rx_dat;
                            default: acc_d = acc_q + {rx_dat, word_q};
                        endcase
                    end
                    if (pay_cnt_q == 16'd1) begin
                        state_d = (opcode_q == OP_ADD32) ? ST_RESULT : ST_OPCODE;
                    end
                end
            end
            ST_RESULT: begin
                // Whole sum goes in at once, so only an empty FIFO can take it.
                if (fifo_empty) begin
                    result_wr = 1'b1;
                    state_d   = ST_OPCODE;
                end
            end
            default: state_d = ST_OPCODE;
        endcase
    end

    // TX FIFO. A push into a full FIFO succeeds only when the same cycle pops.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push_ok    = push && (!fifo_full || pop);
        if (result_wr) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_d[wr_ptr_q + 2'(i)] = acc_q[8*i +: 8];
            end
        end
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = rx_dat;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (result_wr) begin
            fifo_cnt_d = 3'd4;
        end else begin
            fifo_cnt_d = fifo_cnt_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_OPCODE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            pay_cnt_q  <= '0;
            acc_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            pay_cnt_q  <= pay_cnt_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: drives serial packets, decodes TX_o, scoreboards expected bytes.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_alu_top;

    localparam int BIT   = 32;          // PRESCALE 4 -> 32 clocks per bit
    localparam int HALF  = BIT / 2;
    localparam int FRAME = 10 * BIT;
    // Stop midpoint (16) + 2-flop sync + strobe register, then 3 clocks of response, plus margin.
    localparam int LAT_MAX = 24;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic rx = 1'b1;
    logic tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_stop_t = 0;
    bit mon_rst = 1'b0;

    int got[$];
    int got_t[$];
    int exp[$];

    uart_alu_top #(
        .CLK_FREQ_HZ (640),
        .BAUD_RATE   (20),
        .PRESCALE    (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .RX_i    (rx),
        .TX_o    (tx)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset_i) mon_rst = 1'b1;
    end

    // TX line decoder: pushes each decoded byte (or a negative code for a bad frame).
    initial begin : tx_mon
        int cnt;
        int t0;
        int k;
        bit act;
        logic [7:0] sh;
        cnt = 0; t0 = 0; k = 0; act = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (mon_rst) begin
                mon_rst = 1'b0;
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                    t0 = cyc;
                end
            end else begin
                cnt++;
                if (cnt == HALF) begin
                    if (tx !== 1'b0) begin
                        act = 1'b0;
                        got.push_back(-2);
                        got_t.push_back(t0);
                    end
                end else if (cnt > HALF && ((cnt - HALF) % BIT) == 0) begin
                    k = (cnt - HALF) / BIT;
                    if (k <= 8) begin
                        sh[k-1] = tx;
                    end else begin
                        got.push_back((tx === 1'b1) ? int'(sh) : -1);
                        got_t.push_back(t0);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_ok;
        last_stop_t = cyc;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (BIT) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
        send_byte(op, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
    endtask

    // Sends an add32 packet and queues the sum the bench computes itself.
    task automatic add_pkt(input int nops, input logic [31:0] op0, input logic [31:0] op1,
                           input int ntrail);
        logic [31:0] s;
        logic [31:0] op;
        s = 32'd0;
        send_hdr(8'hAD, 16'(4 + 4*nops + ntrail));
        for (int i = 0; i < nops; i++) begin
            op = (i == 0) ? op0 : op1;
            s = s + op;
            for (int j = 0; j < 4; j++) send_byte(op[8*j +: 8], 1'b1);
        end
        for (int i = 0; i < ntrail; i++) send_byte(8'h99, 1'b1);
        for (int j = 0; j < 4; j++) exp.push_back(int'(s[8*j +: 8]));
    endtask

    task automatic wait_tx(input int n);
        int budget;
        budget = 0;
        while (got.size() < n && budget < 8*FRAME) begin
            @(negedge clk);
            budget++;
        end
        repeat (2*FRAME) @(negedge clk);
    endtask

    task automatic test_reset();
        int lows;
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        reset_i = 1'b0;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows != 0) begin bad++; $display("FAIL reset_idle: %0d low clocks want 0", lows); end
        total++;
        if (got.size() != 0) begin bad++; $display("FAIL reset_quiet: %0d bytes want 0", got.size()); end
        got.delete(); got_t.delete();
    endtask

    task automatic test_echo();
        logic [7:0] pl [4];
        int first_stop, e, g;
        pl = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        first_stop = 0;
        send_hdr(8'hEC, 16'd8);
        for (int i = 0; i < 4; i++) begin
            exp.push_back(int'(pl[i]));
            send_byte(pl[i], 1'b1);
            if (i == 0) first_stop = last_stop_t;
        end
        wait_tx(4);
        total++;
        if (got_t.size() == 0 || got_t[0] - first_stop > LAT_MAX) begin
            bad++; $display("FAIL echo_latency: got %0d clocks want <= %0d",
                            (got_t.size() != 0) ? got_t[0] - first_stop : -1, LAT_MAX);
        end
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL echo_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL echo_byte: got %0h want %0h", g, e); end
        end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL echo_idle: got %b want 1", tx); end
        got.delete(); got_t.delete();
    endtask

    task automatic test_header_only();
        int e, g;
        send_hdr(8'hEC, 16'd4);
        send_hdr(8'hEC, 16'd5);
        exp.push_back(32'h5A);
        send_byte(8'h5A, 1'b1);
        wait_tx(1);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL hdr_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL hdr_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    task automatic test_add32();
        int e, g;
        add_pkt(2, 32'h0000_0001, 32'hFFFF_FFFF, 0);   // wraps to 0
        wait_tx(4);
        add_pkt(2, 32'h0000_0002, 32'h0000_0003, 0);
        wait_tx(8);
        add_pkt(0, 32'h0, 32'h0, 0);                   // no operands
        wait_tx(12);
        add_pkt(1, 32'h0000_0007, 32'h0, 2);           // trailing partial word ignored
        wait_tx(16);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL add_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL add_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    task automatic test_back_to_back();
        int e, g;
        add_pkt(2, 32'h1122_3344, 32'h0101_0101, 0);
        wait_tx(4);
        total++;
        if (got_t.size() == 0 || got_t[0] - last_stop_t > LAT_MAX) begin
            bad++; $display("FAIL b2b_latency: got %0d clocks want <= %0d",
                            (got_t.size() != 0) ? got_t[0] - last_stop_t : -1, LAT_MAX);
        end
        for (int i = 0; i + 1 < got_t.size(); i++) begin
            total++;
            if (got_t[i+1] - got_t[i] != FRAME) begin
                bad++; $display("FAIL b2b_spacing: got %0d clocks want %0d", got_t[i+1] - got_t[i], FRAME);
            end
        end
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    task automatic test_unknown_opcode();
        int e, g;
        send_hdr(8'h55, 16'd8);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_hdr(8'hEC, 16'd5);
        exp.push_back(32'hA5);
        send_byte(8'hA5, 1'b1);
        wait_tx(1);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL unk_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL unk_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    task automatic test_reset_mid_packet();
        int e, g;
        logic tx_before;
        send_hdr(8'hEC, 16'd8);
        send_byte(8'h11, 1'b1);
        tx_before = tx;
        total++;
        if (tx_before !== 1'b0) begin bad++; $display("FAIL rst_echo_started: got %b want 0", tx_before); end
        reset_i = 1'b1;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx_high: got %b want 1", tx); end
        reset_i = 1'b0;
        send_hdr(8'hEC, 16'd5);
        exp.push_back(32'hC3);
        send_byte(8'hC3, 1'b1);
        wait_tx(1);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL rst_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL rst_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    task automatic test_framing_error();
        int e, g;
        send_hdr(8'hEC, 16'd7);
        exp.push_back(32'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h77, 1'b0);                        // stop bit low: must vanish
        exp.push_back(32'h22);
        send_byte(8'h22, 1'b1);
        exp.push_back(32'h33);
        send_byte(8'h33, 1'b1);
        send_hdr(8'hEC, 16'd5);
        exp.push_back(32'h44);
        send_byte(8'h44, 1'b1);
        wait_tx(4);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL frm_count: got %0d want %0d", got.size(), exp.size()); end
        while (exp.size() != 0) begin
            e = exp.pop_front();
            g = (got.size() != 0) ? got.pop_front() : -3;
            total++;
            if (g !== e) begin bad++; $display("FAIL frm_byte: got %0h want %0h", g, e); end
        end
        got.delete(); got_t.delete();
    endtask

    initial begin
        test_reset();
        test_echo();
        test_header_only();
        test_add32();
        test_back_to_back();
        test_unknown_opcode();
        test_reset_mid_packet();
        test_framing_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
